// File: rtl/system_pkg.sv
// Shared AHB-Lite bus definitions for the ahbl decoder/slave slice.
// Contents:
//   ADDR_WIDTH, DATA_WIDTH      : system bus widths
//   HTRANS_* / HSIZE_*          : AHB-Lite transfer type and size encodings
//   ahbl_slv_state_e            : SRAM slave data-phase FSM states
package system_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } ahbl_slv_state_e;

endpackage

// File: rtl/ahbl_be_gen.sv
// Byte-lane enable generator for little-endian AHB-Lite transfers.
// Ports:
//   hsize_i     in  3  transfer size (byte/half/word; larger sizes give no lanes)
//   addr_lo_i   in  2  low byte-address bits
//   be_o        out 4  byte-lane enables, bit n = lane n
//   misalign_o  out 1  address not naturally aligned for hsize_i
module ahbl_be_gen
  import system_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = '0;
    misalign_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        misalign_o = |addr_lo_i;
        be_o       = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM responder: DEPTH x 32-bit register-array memory with
// byte/half/word access, programmable wait states and two-cycle ERROR
// responses for illegal transfers.
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   hsel          slave select from decoder
//   haddr         local byte address (ADDR_WIDTH-4 bits)
//   hburst, hmastlock, hprot   not used
//   hsize, htrans, hwrite      address-phase control
//   hwdata        write data (data phase)
//   hreadyin      bus HREADY, qualifies the address phase
//   hrdata        read data, 0 outside a read data phase
//   hreadyout     0 extends the data phase
//   hresp         0 OKAY, 1 ERROR
module ahbl_sram_slave
  import system_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-5:0] haddr,
  input  logic [2:0]            hburst,
  input  logic                  hmastlock,
  input  logic [3:0]            hprot,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hwrite,
  input  logic                  hreadyin,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned HADDR_W = ADDR_WIDTH - 4;

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("ahbl_sram_slave: DATA_WIDTH must be 32");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("ahbl_sram_slave: DEPTH must be a power of 2 and >= 4");
  end
  if (WAIT_STATES > 15) begin : g_ws_chk
    $error("ahbl_sram_slave: WAIT_STATES must be 0..15");
  end

  ahbl_slv_state_e   state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dphase_q, dphase_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        be_q, be_d;

  logic [31:0]       mem_q [DEPTH];

  logic [3:0]        be;
  logic              misalign;
  logic              oor;
  logic              accept;
  logic              illegal;
  logic              commit;

  logic              unused_ok;
  assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0]};

  ahbl_be_gen u_be_gen (
    .hsize_i    (hsize),
    .addr_lo_i  (haddr[1:0]),
    .be_o       (be),
    .misalign_o (misalign)
  );

  // Out of range when any byte-address bit above the array span is set.
  if (IDX_W + 2 < HADDR_W) begin : g_oor
    assign oor = |haddr[HADDR_W-1:IDX_W+2];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // Only states that present hreadyout=1 can take a new address phase.
  assign accept  = hsel & hreadyin & htrans[1] &
                   ((state_q == IDLE) || (state_q == ERR2));
  assign illegal = (hsize > HSIZE_WORD) | misalign | oor;

  // A legal data phase completes in IDLE; a data phase in WAIT is still stalled.
  assign commit = dphase_q & write_q & (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dphase_d  = dphase_q;
    write_d   = write_q;
    idx_d     = idx_q;
    be_d      = be_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      IDLE, ERR2: begin
        hresp    = (state_q == ERR2);
        state_d  = IDLE;
        dphase_d = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = ERR1;
          end else begin
            dphase_d = 1'b1;
            write_d  = hwrite;
            idx_d    = haddr[IDX_W+1:2];
            be_d     = be;
            cnt_d    = 4'(WAIT_STATES);
            if (WAIT_STATES != 0) state_d = WAIT;
          end
        end
      end
      WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = IDLE;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
    end
  end

  // Memory is not reset; an asynchronous reset clears dphase_q so any
  // pending write is dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (dphase_q & ~write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
module tb_ahbl_sram_slave;
  import system_pkg::*;

  logic               clk = 1'b0;
  logic               rstn;
  logic               hsel_v [2];
  logic [27:0]        haddr;
  logic [2:0]         hsize;
  logic [1:0]         htrans;
  logic [31:0]        hwdata;
  logic               hwrite;
  logic               block_ready;
  logic               hreadyin_v  [2];
  logic [31:0]        hrdata_v    [2];
  logic               hreadyout_v [2];
  logic               hresp_v     [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign hreadyin_v[0] = hreadyout_v[0] & ~block_ready;
  assign hreadyin_v[1] = hreadyout_v[1] & ~block_ready;

  ahbl_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .hsel(hsel_v[0]), .haddr(haddr), .hburst(3'b000),
    .hmastlock(1'b0), .hprot(4'b0011), .hsize(hsize), .htrans(htrans),
    .hwdata(hwdata), .hwrite(hwrite), .hreadyin(hreadyin_v[0]),
    .hrdata(hrdata_v[0]), .hreadyout(hreadyout_v[0]), .hresp(hresp_v[0])
  );

  ahbl_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .hsel(hsel_v[1]), .haddr(haddr), .hburst(3'b000),
    .hmastlock(1'b0), .hprot(4'b0011), .hsize(hsize), .htrans(htrans),
    .hwdata(hwdata), .hwrite(hwrite), .hreadyin(hreadyin_v[1]),
    .hrdata(hrdata_v[1]), .hreadyout(hreadyout_v[1]), .hresp(hresp_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    hsel_v[0] = 1'b0;
    hsel_v[1] = 1'b0;
    htrans    = HTRANS_IDLE;
    hwrite    = 1'b0;
    hsize     = HSIZE_WORD;
    haddr     = '0;
  endtask

  task automatic drive_ap(input int d, input logic [1:0] tr, input logic wr,
                          input logic [2:0] sz, input logic [27:0] a);
    hsel_v[0] = (d == 0);
    hsel_v[1] = (d == 1);
    htrans    = tr;
    hwrite    = wr;
    hsize     = sz;
    haddr     = a;
  endtask

  // Single NONSEQ transfer followed by an idle bus; returns completing-cycle
  // read data and the number of stalled data-phase cycles.
  task automatic xfer(input int d, input logic wr, input logic [2:0] sz,
                      input logic [27:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits);
    drive_ap(d, HTRANS_NONSEQ, wr, sz, a);
    tick();
    drive_idle();
    hwdata = wd;
    waits  = 0;
    while (hreadyout_v[d] == 1'b0 && waits < 40) begin
      tick();
      waits++;
    end
    rd = hrdata_v[d];
    tick();
  endtask

  // Four-beat incrementing write burst; returns the number of data-phase cycles.
  task automatic stream4(input int d, input logic [27:0] base, output int cycles);
    int n;
    drive_ap(d, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, base);
    tick();
    cycles = 0;
    for (int b = 0; b < 4; b++) begin
      hwdata = 32'hA000_0000 + 32'(b);
      if (b < 3) drive_ap(d, HTRANS_SEQ, 1'b1, HSIZE_WORD, base + 28'(4 * (b + 1)));
      else drive_idle();
      cycles++;
      n = 0;
      while (hreadyout_v[d] == 1'b0 && n < 40) begin
        tick();
        cycles++;
        n++;
      end
      tick();
    end
  endtask

  task automatic err_xfer(input string tag, input logic [2:0] sz, input logic [27:0] a);
    drive_ap(0, HTRANS_NONSEQ, 1'b1, sz, a);
    tick();
    drive_idle();
    hwdata = 32'hFFFF_FFFF;
    chk({tag, "_err1"}, {30'd0, hresp_v[0], hreadyout_v[0]}, 32'd2);
    tick();
    chk({tag, "_err2"}, {30'd0, hresp_v[0], hreadyout_v[0]}, 32'd3);
    tick();
    chk({tag, "_after"}, {30'd0, hresp_v[0], hreadyout_v[0]}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          w;
    int          cyc;

    rstn        = 1'b0;
    block_ready = 1'b0;
    hwdata      = '0;
    drive_idle();
    tick();
    tick();
    chk("rst_ready0", {31'd0, hreadyout_v[0]}, 32'd1);
    chk("rst_resp0",  {31'd0, hresp_v[0]},     32'd0);
    chk("rst_rdata0", hrdata_v[0],             32'd0);
    chk("rst_ready3", {31'd0, hreadyout_v[1]}, 32'd1);
    rstn = 1'b1;
    tick();

    // Wait-state timing on the WAIT_STATES=3 instance.
    xfer(1, 1'b1, HSIZE_WORD, 28'h040, 32'h1111_1111, rd, w);
    chk("ws3_wr_waits", 32'(w), 32'd3);
    xfer(1, 1'b0, HSIZE_WORD, 28'h040, 32'h0, rd, w);
    chk("ws3_rd_waits", 32'(w), 32'd3);
    chk("ws3_rd_data", rd, 32'h1111_1111);

    // Reset asserted in the middle of a stalled write.
    drive_ap(1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 28'h040);
    tick();
    drive_idle();
    hwdata = 32'h2222_2222;
    tick();
    chk("midwait_ready", {31'd0, hreadyout_v[1]}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, hreadyout_v[1]}, 32'd1);
    chk("async_rst_resp",  {31'd0, hresp_v[1]},     32'd0);
    chk("async_rst_rdata", hrdata_v[1],             32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    xfer(1, 1'b0, HSIZE_WORD, 28'h040, 32'h0, rd, w);
    chk("rst_no_write", rd, 32'h1111_1111);

    // Back-to-back write then read of the same word, zero wait.
    drive_ap(0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 28'h010);
    tick();
    hwdata = 32'hDEAD_BEEF;
    drive_ap(0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 28'h010);
    chk("b2b_wr_ready", {31'd0, hreadyout_v[0]}, 32'd1);
    tick();
    drive_idle();
    chk("b2b_rd_ready", {31'd0, hreadyout_v[0]}, 32'd1);
    chk("b2b_rd_data", hrdata_v[0], 32'hDEAD_BEEF);
    tick();
    chk("idle_rdata", hrdata_v[0], 32'd0);

    // Byte and halfword lanes; unselected lanes carry junk that must not land.
    xfer(0, 1'b1, HSIZE_WORD, 28'h020, 32'h0000_0000, rd, w);
    xfer(0, 1'b1, HSIZE_BYTE, 28'h021, 32'hFFFF_AAFF, rd, w);
    xfer(0, 1'b1, HSIZE_HALF, 28'h022, 32'h1234_FFFF, rd, w);
    xfer(0, 1'b0, HSIZE_WORD, 28'h020, 32'h0, rd, w);
    chk("lanes_word", rd, 32'h1234_AA00);
    chk("lanes_waits", 32'(w), 32'd0);

    // Bursts: full rate with no wait states, 4 cycles per beat with three.
    stream4(0, 28'h100, cyc);
    chk("stream0_cycles", 32'(cyc), 32'd4);
    stream4(1, 28'h180, cyc);
    chk("stream3_cycles", 32'(cyc), 32'd16);
    xfer(0, 1'b0, HSIZE_WORD, 28'h10C, 32'h0, rd, w);
    chk("stream0_beat3", rd, 32'hA000_0003);
    xfer(1, 1'b0, HSIZE_WORD, 28'h184, 32'h0, rd, w);
    chk("stream3_beat1", rd, 32'hA000_0001);

    // Illegal transfers must answer ERROR and leave word 0 alone.
    xfer(0, 1'b1, HSIZE_WORD, 28'h000, 32'h5A5A_5A5A, rd, w);
    err_xfer("misalign_word", HSIZE_WORD, 28'h002);
    err_xfer("misalign_half", HSIZE_HALF, 28'h001);
    err_xfer("hsize3",        3'b011,     28'h000);
    err_xfer("out_of_range",  HSIZE_WORD, 28'h1000);
    xfer(0, 1'b0, HSIZE_WORD, 28'h000, 32'h0, rd, w);
    chk("err_mem_kept", rd, 32'h5A5A_5A5A);

    // Highest legal word.
    xfer(0, 1'b1, HSIZE_WORD, 28'hFFC, 32'hC0FF_EE00, rd, w);
    xfer(0, 1'b0, HSIZE_WORD, 28'hFFC, 32'h0, rd, w);
    chk("top_word", rd, 32'hC0FF_EE00);

    // No-access cycles: BUSY, hsel=0 and hreadyin=0 must not touch word 0x98.
    xfer(0, 1'b1, HSIZE_WORD, 28'h098, 32'h7777_7777, rd, w);
    drive_ap(0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 28'h090);
    tick();
    hwdata = 32'h0000_0090;
    drive_ap(0, HTRANS_BUSY, 1'b1, HSIZE_WORD, 28'h098);
    tick();
    hwdata = 32'hBAD0_BAD0;
    drive_ap(0, HTRANS_SEQ, 1'b1, HSIZE_WORD, 28'h094);
    chk("busy_ready", {31'd0, hreadyout_v[0]}, 32'd1);
    tick();
    hwdata = 32'h0000_0094;
    drive_idle();
    tick();
    drive_ap(0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 28'h098);
    hsel_v[0] = 1'b0;
    tick();
    hwdata = 32'hBAD1_BAD1;
    drive_idle();
    chk("nosel_ready", {31'd0, hreadyout_v[0]}, 32'd1);
    tick();
    drive_ap(0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 28'h098);
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    hwdata = 32'hBAD2_BAD2;
    drive_idle();
    chk("noready_ready", {31'd0, hreadyout_v[0]}, 32'd1);
    chk("noready_resp",  {31'd0, hresp_v[0]},     32'd0);
    tick();
    xfer(0, 1'b0, HSIZE_WORD, 28'h098, 32'h0, rd, w);
    chk("noaccess_mem", rd, 32'h7777_7777);
    xfer(0, 1'b0, HSIZE_WORD, 28'h094, 32'h0, rd, w);
    chk("busy_seq_beat", rd, 32'h0000_0094);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
